// File: rtl/shift_pkg.sv
// Shared types and constants for the shift controller: state/op enums,
// shift-register command encodings and the word/shift-amount widths.
package shift_pkg;

  localparam int WORD_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    F_NOP  = 3'b000,
    F_LOAD = 3'b001,
    F_SLL  = 3'b010,
    F_SRL  = 3'b011,
    F_SRA  = 3'b100,
    F_ROR  = 3'b101
  } funct_e;

  function automatic funct_e op_to_funct(input op_e op);
    case (op)
      OP_SLL:  return F_SLL;
      OP_SRL:  return F_SRL;
      OP_SRA:  return F_SRA;
      default: return F_ROR;
    endcase
  endfunction

endpackage

// File: rtl/shift_ctrl.sv
// Sequencer that drives an external shift register through LOAD/SHIFT/WAIT.
// Build option SHIFT_STEP_EN: shift one bit per cycle using a down-counter.
import shift_pkg::*;

module shift_ctrl (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WORD_W-1:0]  data_in,
  output logic               ready,
  output logic               done,
  output logic [WORD_W-1:0]  result,
  output funct_e             sh_funct,
  output logic [SHAMT_W-1:0] sh_n,
  output logic [WORD_W-1:0]  sh_array,
  input  logic [WORD_W-1:0]  sh_result,
  output state_e             state_dbg
);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // start at any other time is dropped, and done pulses once per taken request.

  state_e               state, state_nxt;
  op_e                  op_q;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [WORD_W-1:0]    data_q;
  logic [WORD_W-1:0]    result_q;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q     <= OP_SLL;
      shamt_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        op_q    <= op_e'(op);
        shamt_q <= shamt;
        data_q  <= data_in;
      end
      if (state == S_WAIT) result_q <= sh_result;
    end
  end

`ifdef SHIFT_STEP_EN
  logic [SHAMT_W-1:0] step_cnt;

  // Counts remaining single-bit steps; SHIFT ends on the step where it reads 1.
  always_ff @(posedge clk) begin
    if (!reset)                                   step_cnt <= '0;
    else if (state == S_LOAD)                     step_cnt <= shamt_q;
    else if (state == S_SHIFT && step_cnt != 5'd1) step_cnt <= step_cnt - 5'd1;
  end
`endif

  always_comb begin
    state_nxt = state;
    sh_funct  = F_NOP;
    sh_n      = '0;
    done      = 1'b0;
    ready     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        sh_funct  = F_LOAD;
        state_nxt = (shamt_q != '0) ? S_SHIFT : S_WAIT;
      end
      S_SHIFT: begin
        sh_funct = op_to_funct(op_q);
`ifdef SHIFT_STEP_EN
        sh_n = SHAMT_W'(1);
        if (step_cnt == 5'd1) state_nxt = S_WAIT;
`else
        sh_n      = shamt_q;
        state_nxt = S_WAIT;
`endif
      end
      S_WAIT: state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign result    = result_q;
  assign sh_array  = data_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl with a behavioural shift register and
// an arithmetic reference model of shift results, latency and command sequence.
module tb_shift_ctrl;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] data_in = 32'd0;
  logic        ready, done;
  logic [31:0] result, sh_array, sh_result;
  funct_e      sh_funct;
  logic [4:0]  sh_n;
  state_e      state_dbg;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];

  shift_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .data_in(data_in), .ready(ready), .done(done), .result(result),
    .sh_funct(sh_funct), .sh_n(sh_n), .sh_array(sh_array),
    .sh_result(sh_result), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- external shift register ----------------
  logic [31:0] sr = 32'd0;
  always_ff @(posedge clk) begin
    case (sh_funct)
      F_LOAD: sr <= sh_array;
      F_SLL:  sr <= sr << sh_n;
      F_SRL:  sr <= sr >> sh_n;
      F_SRA:  sr <= 32'($signed(sr) >>> sh_n);
      F_ROR:  sr <= (sr >> sh_n) | (sr << (6'd32 - {1'b0, sh_n}));
      default: ;
    endcase
  end
  assign sh_result = sr;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input int s, input logic [31:0] d);
    logic [63:0] dd;
    case (o)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: begin
        dd = {{32{d[31]}}, d};
        dd = dd >> s;
        return dd[31:0];
      end
      default: begin
        dd = {d, d};
        dd = dd >> s;
        return dd[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input int s);
`ifdef SHIFT_STEP_EN
    return (s == 0) ? 3 : s + 3;
`else
    return (s == 0) ? 3 : 4;
`endif
  endfunction

  function automatic bit is_shift_cycle(input int c, input int s);
`ifdef SHIFT_STEP_EN
    return (s != 0) && (c >= 2) && (c <= s + 1);
`else
    return (s != 0) && (c == 2);
`endif
  endfunction

  function automatic funct_e exp_funct(input int c, input logic [1:0] o, input int s);
    if (c == 1) return F_LOAD;
    if (!is_shift_cycle(c, s)) return F_NOP;
    case (o)
      2'b00:   return F_SLL;
      2'b01:   return F_SRL;
      2'b10:   return F_SRA;
      default: return F_ROR;
    endcase
  endfunction

  function automatic logic [4:0] exp_n(input int c, input int s);
    if (!is_shift_cycle(c, s)) return 5'd0;
`ifdef SHIFT_STEP_EN
    return 5'd1;
`else
    return 5'(s);
`endif
  endfunction

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d, input string name);
    int done_c;
    logic [31:0] exp;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b expected 1", name, ready);
    end
    op = o; shamt = s; data_in = d; start = 1'b1;
    exp_q.push_back(ref_shift(o, int'(s), d));
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); shamt = 5'($urandom); data_in = $urandom;
    done_c = -1;
    for (int c = 1; c <= 40; c++) begin
      vectors++;
      if (sh_funct !== exp_funct(c, o, int'(s)) || sh_n !== exp_n(c, int'(s))) begin
        errors++;
        $display("FAIL %s cmd_c%0d: got funct=%0d n=%0d expected funct=%0d n=%0d",
                 name, c, sh_funct, sh_n, exp_funct(c, o, int'(s)), exp_n(c, int'(s)));
      end
      if (c == 1) begin
        vectors++;
        if (sh_array !== d) begin
          errors++; $display("FAIL %s sh_array: got %h expected %h", name, sh_array, d);
        end
      end
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (done_c != exp_lat(int'(s))) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, done_c, exp_lat(int'(s)));
    end
    vectors++;
    if (result !== exp) begin
      errors++; $display("FAIL %s result: got %h expected %h", name, result, exp);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL %s after_done: got done=%b ready=%b result=%h expected done=0 ready=1 result=%h",
               name, done, ready, result, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (state_dbg !== S_IDLE || result !== 32'd0 || done !== 1'b0 ||
        sh_funct !== F_NOP || sh_n !== 5'd0 || sh_array !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got st=%0d res=%h done=%b f=%0d n=%0d arr=%h expected 0/0/0/0/0/0",
               state_dbg, result, done, sh_funct, sh_n, sh_array);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_directed();
    run_op(2'b00, 5'd4,  32'h0000_0001, "sll_1_by_4");
    run_op(2'b10, 5'd31, 32'h8000_0000, "sra_msb_by_31");
    run_op(2'b01, 5'd31, 32'h8000_0000, "srl_msb_by_31");
    run_op(2'b11, 5'd1,  32'h0000_0001, "ror_1_by_1");
    run_op(2'b11, 5'd0,  32'h1234_5678, "ror_by_0");
    run_op(2'b00, 5'd5,  32'h0000_0001, "sll_1_by_5");
    run_op(2'b10, 5'd7,  32'h7654_3210, "sra_pos_by_7");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_op(2'($urandom), 5'($urandom_range(0, 31)), $urandom, "random");
  endtask

  task automatic test_back_to_back();
    int acc, dn;
    int done_at[$];
    int l;
    logic [31:0] d;
    d = $urandom | 32'h1;
    l = exp_lat(4);
    exp_q.push_back(ref_shift(2'b11, 4, d));
    exp_q.push_back(ref_shift(2'b11, 4, d));
    acc = 0; dn = 0;
    @(negedge clk);
    op = 2'b11; shamt = 5'd4; data_in = d; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) start = 1'b0;
      if (done === 1'b1) begin
        dn++;
        done_at.push_back(c);
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_done: got done at cycle %0d expected none", c);
        end else if (result !== exp_q[0]) begin
          errors++; $display("FAIL b2b_result: got %h expected %h", result, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (ready === 1'b1 && start === 1'b1) acc++;
      @(negedge clk);
    end
    exp_q.delete();
    vectors++;
    if (acc != 2 || dn != 2) begin
      errors++; $display("FAIL b2b_count: got accepts=%0d dones=%0d expected 2/2", acc, dn);
    end
    vectors++;
    if (done_at.size() != 2 || done_at[0] != l || done_at[1] != 2 * l + 1) begin
      errors++;
      $display("FAIL b2b_timing: got %0d dones first=%0d expected cycles %0d and %0d",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, l, 2 * l + 1);
    end
  endtask

  task automatic test_reset_mid_op();
    int dn;
    @(negedge clk);
    op = 2'b00; shamt = 5'd31; data_in = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (state_dbg !== S_SHIFT) begin
      errors++; $display("FAIL abort_in_shift: got state %0d expected %0d", state_dbg, S_SHIFT);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (state_dbg !== S_IDLE || result !== 32'd0 || done !== 1'b0 || ready !== 1'b1 ||
        sh_funct !== F_NOP || sh_n !== 5'd0) begin
      errors++;
      $display("FAIL abort_state: got st=%0d res=%h done=%b ready=%b f=%0d n=%0d expected idle/0/0/1/0/0",
               state_dbg, result, done, ready, sh_funct, sh_n);
    end
    reset = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    vectors++;
    if (dn != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dn);
    end
    run_op(2'b00, 5'd1, 32'h0000_0003, "sll_3_by_1_after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
